ex_stage: RTL

Execute stage and receiving end of the ID→EX req/ack handshake. Accepts a decoded packet {opB[15:0], opA[15:0], opcode[4:0], rd[3:0]} from ID and acknowledges it. Executes ALU, compare, iterative mul/div and motion-command ops, then returns results on the WB bus that feeds the ID register-file write port.

---
 rtl/ex_stage_pkg.sv | 63 ++++++
 rtl/ex_muldiv.sv | 98 +++++++++
 rtl/ex_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, opcodes, FSM states,
// flag bit positions and the layout of the ID->EX handshake packet.
package ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int OP_W   = 5;
  localparam int HS_W   = 42;
  localparam int CNT_W  = $clog2(DATA_W);

  // Handshake field offsets; bit HS_W-1 carries nothing.
  localparam int HS_RD_LSB  = 0;
  localparam int HS_OPC_LSB = HS_RD_LSB + REG_AW;
  localparam int HS_OPA_LSB = HS_OPC_LSB + OP_W;
  localparam int HS_OPB_LSB = HS_OPA_LSB + DATA_W;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [OP_W-1:0] OP_MOV            = 5'd1;
  localparam logic [OP_W-1:0] OP_ADD            = 5'd2;
  localparam logic [OP_W-1:0] OP_SUB            = 5'd3;
  localparam logic [OP_W-1:0] OP_AND            = 5'd4;
  localparam logic [OP_W-1:0] OP_OR             = 5'd5;
  localparam logic [OP_W-1:0] OP_NOT            = 5'd6;
  localparam logic [OP_W-1:0] OP_CMP            = 5'd7;
  localparam logic [OP_W-1:0] OP_OB_CHECK       = 5'd8;
  localparam logic [OP_W-1:0] OP_VELOCITY_GUARD = 5'd9;
  localparam logic [OP_W-1:0] OP_MULT           = 5'd10;
  localparam logic [OP_W-1:0] OP_DIV            = 5'd11;
  localparam logic [OP_W-1:0] OP_MOVE_LEFT      = 5'd12;
  localparam logic [OP_W-1:0] OP_MOVE_RIGHT     = 5'd13;
  localparam logic [OP_W-1:0] OP_STOP           = 5'd14;
  localparam logic [OP_W-1:0] OP_CONTINUE       = 5'd15;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_EXEC = 2'd1,
    EX_ITER = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_a;
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
  } ex_pkt_t;

  function automatic logic [3:0] arith_flags(input logic [DATA_W-1:0] res,
                                             input logic carry,
                                             input logic ovf);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[DATA_W-1];
    f[FLAG_C] = carry;
    f[FLAG_V] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative unit, one bit per cycle for DATA_W cycles: shift-add multiply
// (low half) and, when EX_DIV_EN is defined, restoring unsigned divide.
module ex_muldiv
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div0
);

  logic              running;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc, x, y;
  logic [DATA_W-1:0] acc_n, x_n, y_n;
  logic              load_div;
  logic              is_div;

`ifdef EX_DIV_EN
  logic [DATA_W:0] shifted, diff;

  assign load_div = (op == OP_DIV);

  // Divide: acc is the partial remainder, x shifts the dividend out and the
  // quotient in. A zero divisor never borrows, so the quotient saturates.
  always_comb begin
    shifted = {acc, x[DATA_W-1]};
    diff    = shifted - {1'b0, y};
    acc_n   = acc;
    x_n     = x;
    y_n     = y;
    if (is_div) begin
      if (!diff[DATA_W]) begin
        acc_n = diff[DATA_W-1:0];
        x_n   = {x[DATA_W-2:0], 1'b1};
      end else begin
        acc_n = shifted[DATA_W-1:0];
        x_n   = {x[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_n = x[0] ? acc + y : acc;
      x_n   = x >> 1;
      y_n   = y << 1;
    end
  end

  assign result = is_div ? x_n : acc_n;
  assign div0   = is_div && (y == '0);
`else
  logic op_unused;
  assign op_unused = ^op;
  assign load_div  = 1'b0;

  always_comb begin
    acc_n = x[0] ? acc + y : acc;
    x_n   = x >> 1;
    y_n   = y << 1;
  end

  assign result = acc_n;
  assign div0   = 1'b0;
`endif

  // Combinational done lets the stage register the final value directly.
  assign done = running && (cnt == CNT_W'(DATA_W - 1));

  // NOTE: datapath registers are reset too; an aborted operation must not
  // leave stale operands that a later reset-free path could expose.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
      is_div  <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      is_div  <= load_div;
      x       <= load_div ? a : b;
      y       <= load_div ? b : a;
    end else if (running) begin
      acc     <= acc_n;
      x       <= x_n;
      y       <= y_n;
      cnt     <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: accepts ID packets over req/ack, runs ALU/compare/mul/div/
// motion ops and drives the WB bus. EX_DIV_EN enables the divide path.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [HS_W-1:0]   handshake_data,
  output logic              ack,
  output logic [DATA_W-1:0] WB_data,
  output logic [REG_AW-1:0] WB_reg_addr,
  output logic              WB_reg_write,
  output logic [3:0]        flags,
  output logic              cmd_valid,
  output logic [OP_W-1:0]   cmd_op,
  output logic              busy,
  output logic              illegal
);

  ex_state_e state, state_n;
  ex_pkt_t   pkt;

  logic              capture, ack_n, md_start;
  logic              wb_write_n, cmd_valid_n, illegal_n;
  logic [DATA_W-1:0] wb_data_n;
  logic [REG_AW-1:0] wb_addr_n;
  logic [3:0]        flags_n;
  logic [OP_W-1:0]   cmd_op_n;
  logic [DATA_W:0]   sum, dif;

  logic              md_done, md_div0;
  logic [DATA_W-1:0] md_result;

  logic hs_unused;
  assign hs_unused = handshake_data[HS_W-1];

  assign busy = (state != EX_IDLE);

  ex_muldiv u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .op      (pkt.opcode),
    .a       (pkt.op_a),
    .b       (pkt.op_b),
    .done    (md_done),
    .result  (md_result),
    .div0    (md_div0)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    capture     = 1'b0;
    ack_n       = 1'b0;
    md_start    = 1'b0;
    wb_write_n  = 1'b0;
    wb_data_n   = WB_data;
    wb_addr_n   = WB_reg_addr;
    flags_n     = flags;
    cmd_valid_n = 1'b0;
    cmd_op_n    = cmd_op;
    illegal_n   = 1'b0;
    sum         = {1'b0, pkt.op_a} + {1'b0, pkt.op_b};
    dif         = {1'b0, pkt.op_a} - {1'b0, pkt.op_b};

    unique case (state)
      EX_IDLE: begin
        if (req && !ack) begin
          capture = 1'b1;
          ack_n   = 1'b1;
          state_n = EX_EXEC;
        end
      end
      EX_EXEC: begin
        state_n   = EX_IDLE;
        wb_addr_n = pkt.rd;
        case (pkt.opcode)
          OP_MOV: begin wb_write_n = 1'b1; wb_data_n = pkt.op_a; end
          OP_ADD: begin
            wb_write_n = 1'b1;
            wb_data_n  = sum[DATA_W-1:0];
            flags_n    = arith_flags(sum[DATA_W-1:0], sum[DATA_W],
                           (pkt.op_a[DATA_W-1] == pkt.op_b[DATA_W-1]) &&
                           (sum[DATA_W-1] != pkt.op_a[DATA_W-1]));
          end
          OP_SUB, OP_CMP: begin
            wb_write_n = (pkt.opcode == OP_SUB);
            wb_data_n  = (pkt.opcode == OP_SUB) ? dif[DATA_W-1:0] : WB_data;
            flags_n    = arith_flags(dif[DATA_W-1:0], dif[DATA_W],
                           (pkt.op_a[DATA_W-1] != pkt.op_b[DATA_W-1]) &&
                           (dif[DATA_W-1] != pkt.op_a[DATA_W-1]));
          end
          OP_AND: begin wb_write_n = 1'b1; wb_data_n = pkt.op_a & pkt.op_b; end
          OP_OR:  begin wb_write_n = 1'b1; wb_data_n = pkt.op_a | pkt.op_b; end
          OP_NOT: begin wb_write_n = 1'b1; wb_data_n = ~pkt.op_a; end
          OP_OB_CHECK: begin
            wb_write_n = 1'b1;
            wb_data_n  = (pkt.op_a < pkt.op_b) ? DATA_W'(1) : '0;
          end
          OP_VELOCITY_GUARD: begin
            wb_write_n = 1'b1;
            wb_data_n  = (pkt.op_a < pkt.op_b) ? pkt.op_a : pkt.op_b;
          end
`ifdef EX_DIV_EN
          OP_MULT, OP_DIV: begin md_start = 1'b1; state_n = EX_ITER; end
`else
          OP_MULT: begin md_start = 1'b1; state_n = EX_ITER; end
`endif
          OP_MOVE_LEFT, OP_MOVE_RIGHT, OP_STOP, OP_CONTINUE: begin
            cmd_valid_n = 1'b1;
            cmd_op_n    = pkt.opcode;
          end
          default: illegal_n = 1'b1;
        endcase
      end
      EX_ITER: begin
        if (md_done) begin
          wb_write_n = 1'b1;
          wb_data_n  = md_result;
          wb_addr_n  = pkt.rd;
          if (md_div0) flags_n[FLAG_V] = 1'b1;
          state_n    = EX_IDLE;
        end
      end
      default: state_n = EX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= EX_IDLE;
      pkt          <= '0;
      ack          <= 1'b0;
      WB_data      <= '0;
      WB_reg_addr  <= '0;
      WB_reg_write <= 1'b0;
      flags        <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= '0;
      illegal      <= 1'b0;
    end else begin
      state        <= state_n;
      if (capture) pkt <= ex_pkt_t'(handshake_data[HS_W-2:0]);
      ack          <= ack_n;
      WB_data      <= wb_data_n;
      WB_reg_addr  <= wb_addr_n;
      WB_reg_write <= wb_write_n;
      flags        <= flags_n;
      cmd_valid    <= cmd_valid_n;
      cmd_op       <= cmd_op_n;
      illegal      <= illegal_n;
    end
  end

endmodule
